// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with register-based arrays.
// Hits are served combinationally; a miss fetches one word from the memory controller.
module icache #(
  parameter  int INDEX_BITS = 6,
  localparam int TAG_BITS   = 32 - INDEX_BITS - 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        fetch_en,
  input  logic [31:0] fetch_pc,
  input  logic        flush,
  output logic        fetch_hit,
  output logic [31:0] fetch_inst,
  output logic        mem_en,
  output logic [31:0] mem_pc,
  input  logic        mem_done,
  input  logic [31:0] mem_data
);

  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic {
    IDLE,
    MISS
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_arr  [LINES];
  logic [31:0]         data_arr [LINES];

  logic [INDEX_BITS-1:0] req_index, fill_index;
  logic [TAG_BITS-1:0]   req_tag, fill_tag;
  logic                  hit;
  logic                  start_miss;
  logic                  fill;

  // Byte-offset bits never select anything in a word-per-line cache.
  logic unused_pc_bits;
  assign unused_pc_bits = ^fetch_pc[1:0];

  assign req_index  = fetch_pc[INDEX_BITS+1:2];
  assign req_tag    = fetch_pc[31:INDEX_BITS+2];
  assign fill_index = mem_pc[INDEX_BITS+1:2];
  assign fill_tag   = mem_pc[31:INDEX_BITS+2];

  // Lookup is independent of the FSM state, so hit-under-miss comes for free.
  assign hit        = fetch_en & rdy & ~flush & valid_q[req_index]
                    & (tag_arr[req_index] == req_tag);
  assign fetch_hit  = hit;
  assign fetch_inst = hit ? data_arr[req_index] : 32'h0;

  // NOTE: every output of an always_comb gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d    = state_q;
    mem_en     = 1'b0;
    start_miss = 1'b0;
    fill       = 1'b0;
    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (fetch_en && !flush && !hit) begin
            start_miss = 1'b1;
            state_d    = MISS;
          end
        end
        MISS: begin
          // Dropped in the done cycle: the controller is idle again and would
          // otherwise latch a second request.
          mem_en = ~mem_done;
          if (mem_done) begin
            fill    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order between blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_pc <= 32'h0;
    end else if (start_miss) begin
      mem_pc <= {fetch_pc[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[fill_index] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays are deliberately left without reset; the valid
  // bits are the only state that must be cleared, which keeps the arrays as
  // plain enable flops.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_arr[fill_index]  <= fill_tag;
      data_arr[fill_index] <= mem_data;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: stimulus pushes expected hits and memory requests,
// a monitor and a memory-controller model pop and compare them.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        fetch_en = 1'b0;
  logic [31:0] fetch_pc = 32'h0;
  logic        flush = 1'b0;
  logic        fetch_hit;
  logic [31:0] fetch_inst;
  logic        mem_en;
  logic [31:0] mem_pc;
  logic        mem_done = 1'b0;
  logic [31:0] mem_data = 32'h0;

  icache dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .fetch_en  (fetch_en),
    .fetch_pc  (fetch_pc),
    .flush     (flush),
    .fetch_hit (fetch_hit),
    .fetch_inst(fetch_inst),
    .mem_en    (mem_en),
    .mem_pc    (mem_pc),
    .mem_done  (mem_done),
    .mem_data  (mem_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;
  int mem_lat  = 3;

  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_mem_q[$];

  bit          mem_busy = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    case (a)
      32'h0000_1004: return 32'h0051_0113;
      32'h0000_0100: return 32'hAAAA_AAAA;
      32'h0000_0200: return 32'hBBBB_BBBB;
      default:       return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  // Monitor: compares every presented hit against the scoreboard and watches
  // the request line while a memory transaction is outstanding.
  always @(negedge clk) begin
    if (fetch_hit) begin
      if (exp_inst_q.size() == 0) check("unexpected_hit", 32'(fetch_hit), 32'h0);
      else check("fetch_inst", fetch_inst, exp_inst_q.pop_front());
    end
    if (mem_done) check("mem_en_in_done_cycle", 32'(mem_en), 32'h0);
    if (mem_busy && rdy && !mem_done && !rst) check("mem_en_held", 32'(mem_en), 32'h1);
  end

  // Memory-controller model: accepts a request when idle, answers after
  // mem_lat ready cycles with a one-cycle mem_done pulse.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      mem_done = 1'b0;
      if (rst) begin
        mem_busy = 1'b0;
      end else if (!mem_busy && mem_en) begin
        mem_busy = 1'b1;
        mem_addr = mem_pc;
        mem_cnt  = 0;
        n_txn++;
        if (exp_mem_q.size() == 0) check("spurious_mem_req", 32'(mem_en), 32'h0);
        else check("mem_pc_req", mem_pc, exp_mem_q.pop_front());
      end else if (mem_busy && rdy) begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          mem_done = 1'b1;
          mem_data = word_of(mem_addr);
          mem_busy = 1'b0;
        end
      end
    end
  end

  // Inputs are applied at posedge+1; settle moves to posedge+6 and checks.
  task automatic settle(input logic exp_hit, input logic [31:0] exp_inst);
    if (exp_hit) exp_inst_q.push_back(exp_inst);
    #5;
    check("fetch_hit", 32'(fetch_hit), 32'(exp_hit));
    check("hit_served", 32'(exp_inst_q.size()), 32'h0);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      settle(1'b0, 32'h0);
      if (mem_done) begin
        seen = 1'b1;
        break;
      end
      adv();
    end
    check("mem_done_seen", 32'(seen), 32'h1);
  endtask

  task automatic do_miss(input logic [31:0] pc);
    fetch_en = 1'b1;
    fetch_pc = pc;
    flush    = 1'b0;
    exp_mem_q.push_back(pc);
    settle(1'b0, 32'h0);
    adv();
    settle(1'b0, 32'h0);
    check("mem_en_after_miss", 32'(mem_en), 32'h1);
    check("mem_pc_after_miss", mem_pc, pc);
    adv();
    wait_done();
    adv();
    settle(1'b1, word_of(pc));
    adv();
    fetch_en = 1'b0;
  endtask

  initial begin
    int          txn0;
    logic [31:0] base;

    // Reset state
    adv();
    check("rst_fetch_hit", 32'(fetch_hit), 32'h0);
    check("rst_mem_en", 32'(mem_en), 32'h0);
    check("rst_mem_pc", mem_pc, 32'h0);
    check("rst_fetch_inst", fetch_inst, 32'h0);
    adv();
    rst = 1'b0;

    // 1. Cold miss
    mem_lat = 5;
    do_miss(32'h0000_1004);

    // 2. Conflict eviction
    mem_lat = 3;
    do_miss(32'h0000_0100);
    do_miss(32'h0000_0200);
    do_miss(32'h0000_0100);

    // 3. Flush during miss, flush on a resident line, flush with a miss condition
    mem_lat = 6;
    fetch_en = 1'b1;
    fetch_pc = 32'h0000_2000;
    exp_mem_q.push_back(32'h0000_2000);
    settle(1'b0, 32'h0);
    adv();
    fetch_en = 1'b0;
    settle(1'b0, 32'h0);
    check("mem_en_miss", 32'(mem_en), 32'h1);
    adv();
    flush    = 1'b1;
    fetch_en = 1'b1;
    fetch_pc = 32'h0000_0100;
    settle(1'b0, 32'h0);
    check("mem_en_under_flush", 32'(mem_en), 32'h1);
    adv();
    flush    = 1'b0;
    fetch_en = 1'b0;
    wait_done();
    adv();
    fetch_en = 1'b1;
    fetch_pc = 32'h0000_2000;
    settle(1'b1, word_of(32'h0000_2000));
    adv();
    flush = 1'b1;
    settle(1'b0, 32'h0);
    adv();
    fetch_pc = 32'h0000_3000;
    settle(1'b0, 32'h0);
    adv();
    flush    = 1'b0;
    fetch_en = 1'b0;
    settle(1'b0, 32'h0);
    check("no_miss_on_flush", 32'(mem_en), 32'h0);
    adv();

    // 4. Hit-under-miss and rdy stall
    mem_lat = 3;
    do_miss(32'h0000_0040);
    mem_lat = 10;
    fetch_en = 1'b1;
    fetch_pc = 32'h0000_0080;
    exp_mem_q.push_back(32'h0000_0080);
    settle(1'b0, 32'h0);
    adv();
    fetch_pc = 32'h0000_0040;
    settle(1'b1, word_of(32'h0000_0040));
    check("mem_en_hit_under_miss", 32'(mem_en), 32'h1);
    adv();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle(1'b0, 32'h0);
      check("mem_en_stalled", 32'(mem_en), 32'h0);
      adv();
    end
    rdy      = 1'b1;
    fetch_en = 1'b0;
    settle(1'b0, 32'h0);
    check("mem_en_resume", 32'(mem_en), 32'h1);
    check("mem_pc_resume", mem_pc, 32'h0000_0080);
    adv();
    wait_done();
    adv();
    fetch_en = 1'b1;
    fetch_pc = 32'h0000_0080;
    settle(1'b1, word_of(32'h0000_0080));
    adv();
    fetch_en = 1'b0;

    // 5. Async reset mid-miss
    mem_lat = 10;
    fetch_en = 1'b1;
    fetch_pc = 32'h0000_0500;
    exp_mem_q.push_back(32'h0000_0500);
    settle(1'b0, 32'h0);
    adv();
    fetch_en = 1'b0;
    settle(1'b0, 32'h0);
    check("mem_en_before_rst", 32'(mem_en), 32'h1);
    adv();
    #2;
    rst = 1'b1;
    #1;
    check("mem_en_async_rst", 32'(mem_en), 32'h0);
    adv();
    adv();
    rst = 1'b0;
    mem_lat = 2;
    do_miss(32'h0000_0040);

    // 6. One transaction per miss over 100 sequential PCs
    base = 32'h8000_0000 | ($urandom & 32'h00FF_FFFC);
    txn0 = n_txn;
    for (int i = 0; i < 100; i++) begin
      mem_lat = $urandom_range(1, 4);
      do_miss(base + 32'(4 * i));
    end
    check("txn_per_miss", 32'(n_txn - txn0), 32'd100);
    for (int i = 90; i < 100; i++) begin
      fetch_en = 1'b1;
      fetch_pc = base + 32'(4 * i);
      settle(1'b1, word_of(base + 32'(4 * i)));
      adv();
    end
    fetch_en = 1'b0;
    repeat (3) adv();
    check("mem_q_drained", 32'(exp_mem_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, one-word-per-line instruction cache between the instruction fetch unit and the memory controller's instruction-fetch port.
- Serves fetch requests combinationally on a hit.
- On a miss, issues a single 4-byte fetch to the memory controller, fills the line, and serves the request on the following cycle.
- Lines are never written by stores; instruction memory is treated as read-only.

Parameters:
- INDEX_BITS, 6, log2 of line count (64 lines)
- TAG_BITS, 32-INDEX_BITS-2, tag width (derived; not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global ready; when low the block freezes
- fetch_en  in  1  fetch unit requests the instruction at fetch_pc
- fetch_pc  in  32  request address; bits [1:0] ignored
- flush  in  1  misprediction/flush from the ROB; suppresses fetch_hit this cycle
- fetch_hit  out  1  fetch_inst valid this cycle (combinational)
- fetch_inst  out  32  instruction word
- mem_en  out  1  fetch request to the memory controller (combinational)
- mem_pc  out  32  word-aligned miss address (registered)
- mem_done  in  1  one-cycle pulse: mem_data valid
- mem_data  in  32  fetched little-endian word

Behaviour:
Address split:
- index = pc[INDEX_BITS+1:2]
- tag = pc[31:INDEX_BITS+2]

Storage:
- valid[2^INDEX_BITS] flops, tag array, data array, all register-based so lookup is same-cycle.

Reset (async, rst=1):
- All valid = 0; state = IDLE; mem_pc = 0.
- Outputs: fetch_hit = 0, mem_en = 0, fetch_inst = 0 (don't-care, driven 0).
- Reset mid-miss abandons the miss. The memory controller shares rst, so no stale mem_done can arrive.

Lookup (combinational):
- hit = fetch_en & rdy & !flush & valid[index] & (tag_arr[index] == tag).
- fetch_hit = hit; fetch_inst = data_arr[index].
- fetch_inst is don't-care when fetch_hit = 0.
- Hits are served in any state, so hit-under-miss is allowed.

State machine (updates only when rdy=1):
- IDLE:
  - If fetch_en & !flush & !hit: mem_pc <= {fetch_pc[31:2], 2'b00}; go to MISS.
  - Otherwise stay in IDLE.
- MISS:
  - mem_en = !mem_done; mem_pc is held stable.
  - On mem_done: valid[mem_pc index] <= 1, tag and data written from mem_pc and mem_data; go to IDLE.
  - flush during MISS does not cancel the miss. The in-flight fetch completes and fills, because the data is correct for mem_pc.

mem_en rules:
- mem_en is 0 in IDLE.
- mem_en must be low in the mem_done cycle. The memory controller is back in its idle state that cycle and would otherwise accept a spurious request.
- mem_en stays asserted across any cycles where the controller serves the load/store buffer first. Completion is signalled only by mem_done.

Latency:
- Hit: 0 cycles.
- Miss: request goes out the cycle after the miss is detected; fill happens on the mem_done edge; the hit is served the cycle after mem_done if fetch_pc is unchanged.
- Back-to-back miss: the next miss request is issued one cycle after returning to IDLE.

rdy = 0:
- fetch_hit and mem_en are forced 0.
- State, arrays and mem_pc hold.
- mem_done is not expected while rdy is low. If mem_done does arrive, it is ignored.

Simultaneous events:
- mem_done and a lookup to the same index in one cycle: the lookup sees the old contents; the fill takes effect next cycle.
- flush together with a miss condition in IDLE: no miss is started.

Aliasing:
- Addresses differing only above the index share a line; a fill evicts the previous tag unconditionally.

Test Plan:
1. Cold miss:
   - Stimulus: reset, then fetch_en=1, fetch_pc=0x0000_1004.
   - Required: fetch_hit=0; next cycle mem_en=1, mem_pc=0x1004.
   - Drive mem_done=1, mem_data=0x0051_0113 after 5 cycles: mem_en=0 that cycle; next cycle fetch_hit=1, fetch_inst=0x0051_0113.
2. Conflict eviction:
   - Stimulus: fill 0x0000_0100 with 0xAAAA_AAAA, then request 0x0000_0200 (same index, INDEX_BITS=6) and fill it with 0xBBBB_BBBB.
   - Required: 0x200 hits with 0xBBBB_BBBB; re-requesting 0x100 misses and drives mem_pc=0x100.
3. Flush during miss:
   - Stimulus: miss on 0x2000; pulse flush for 1 cycle while in MISS.
   - Required: mem_en stays 1 until mem_done.
   - Subsequent fetch_pc=0x2000 hits; fetch_hit=0 in the flush cycle even for a resident line.
4. Hit-under-miss and stall:
   - Stimulus: resident 0x40; miss pending on 0x80; request 0x40; then drop rdy for 3 cycles.
   - Required: fetch_hit=1 for 0x40 while mem_en=1.
   - During rdy=0: fetch_hit=0, mem_en=0, state preserved. After rdy returns: mem_en=1, mem_pc=0x80.
5. Async reset mid-miss:
   - Stimulus: assert rst between clock edges while in MISS.
   - Required: mem_en=0 immediately; after release, previously filled lines miss.
6. No spurious request:
   - Stimulus: model the memory controller with the done-cycle handshake.
   - Required: exactly one memory transaction per miss, checked over 100 random sequential PCs.
